// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (write/read) round-robin arbiter for one shared synchronous memory port
//
// Ports:
//   clk, n_rst            clock (rising edge) and asynchronous active-low reset
//   w_req/w_addr/w_data   write requester; level request held until w_gnt
//   w_gnt                 one-cycle pulse in the cycle the write is on the memory port
//   r_req/r_addr          read requester; level request held until r_gnt
//   r_gnt                 one-cycle pulse in the cycle the read address is on the memory port
//   r_valid/r_data        r_valid pulses two cycles after r_gnt; r_data holds the last read word
//   mem_addr/mem_wen/
//   mem_wdata/mem_rdata   shared memory port; mem_rdata is valid one clock after mem_addr
//   busy                  high whenever the arbiter is not idle
module mem_port_arbiter #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 3
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               w_req,
    input  logic [A_WIDTH-1:0] w_addr,
    input  logic [D_WIDTH-1:0] w_data,
    output logic               w_gnt,
    input  logic               r_req,
    input  logic [A_WIDTH-1:0] r_addr,
    output logic               r_gnt,
    output logic               r_valid,
    output logic [D_WIDTH-1:0] r_data,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic               mem_wen,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_RD_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_w;   // 1: the most recent grant went to the writer
    logic   w_pick_w;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Requests are only looked at while idle; a tie goes to whoever did
    // not win last time.
    always_comb begin
        w_next_state = r_state;
        w_pick_w     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pick_w = w_req && (!r_req || !r_last_w);
                if (w_pick_w) begin
                    w_next_state = ST_WR;
                end else if (r_req) begin
                    w_next_state = ST_RD;
                end
            end
            ST_WR:      w_next_state = ST_IDLE;
            ST_RD:      w_next_state = ST_RD_WAIT;
            ST_RD_WAIT: w_next_state = ST_RD_DONE;
            ST_RD_DONE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Every output is a flop loaded from the next state, so each one lines
    // up with the state it belongs to without any input-to-output path.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_gnt     <= 1'b0;
            r_gnt     <= 1'b0;
            r_valid   <= 1'b0;
            mem_wen   <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_data    <= '0;
            r_last_w  <= 1'b0;
        end else begin
            w_gnt   <= (w_next_state == ST_WR);
            mem_wen <= (w_next_state == ST_WR);
            r_gnt   <= (w_next_state == ST_RD);
            r_valid <= (w_next_state == ST_RD_DONE);
            busy    <= (w_next_state != ST_IDLE);
            if (r_state == ST_IDLE && w_next_state == ST_WR) begin
                mem_addr  <= w_addr;
                mem_wdata <= w_data;
                r_last_w  <= 1'b1;
            end
            if (r_state == ST_IDLE && w_next_state == ST_RD) begin
                mem_addr <= r_addr;
                r_last_w <= 1'b0;
            end
            // The memory returns the word during RD_WAIT.
            if (r_state == ST_RD_WAIT) begin
                r_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       w_req = 1'b0;
    logic [2:0] w_addr = '0;
    logic [7:0] w_data = '0;
    logic       w_gnt;
    logic       r_req = 1'b0;
    logic [2:0] r_addr = '0;
    logic       r_gnt;
    logic       r_valid;
    logic [7:0] r_data;
    logic [2:0] mem_addr;
    logic       mem_wen;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;

    mem_port_arbiter #(.D_WIDTH(8), .A_WIDTH(3)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .w_req     (w_req),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .w_gnt     (w_gnt),
        .r_req     (r_req),
        .r_addr    (r_addr),
        .r_gnt     (r_gnt),
        .r_valid   (r_valid),
        .r_data    (r_data),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory attached to the shared port.
    logic [7:0] bmem [8] = '{8'h11, 8'h22, 8'h33, 8'h5C, 8'h44, 8'h55, 8'h66, 8'h77};
    always @(posedge clk) begin
        if (mem_wen) bmem[mem_addr] <= mem_wdata;
        mem_rdata <= bmem[mem_addr];
    end

    // Reference model: a timeline of expected per-cycle events. Slot 0 is
    // the current cycle; a grant books the following cycles of the port.
    logic [7:0] model_mem [8] = '{8'h11, 8'h22, 8'h33, 8'h5C, 8'h44, 8'h55, 8'h66, 8'h77};
    bit         e_w [4];
    bit         e_rg [4];
    bit         e_rv [4];
    bit         e_busy [4];
    bit         e_ru [4];
    logic [7:0] e_rd [4];
    logic [2:0] e_wa [4];
    logic [7:0] e_wd [4];
    logic [2:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    bit         last_w;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc_n = 0;
    int   wg_cyc = 0;
    int   rg_cyc = 0;
    int   n_wen = 0;
    byte  gq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            e_w[i] = 0; e_rg[i] = 0; e_rv[i] = 0; e_busy[i] = 0; e_ru[i] = 0;
            e_rd[i] = '0; e_wa[i] = '0; e_wd[i] = '0;
        end
        m_addr = '0; m_wdata = '0; m_rdata = '0; last_w = 0;
    endtask

    // Called with this cycle's inputs in place, just before the edge that ends it.
    task automatic step_model();
        bit gw, gr;
        if (e_w[0]) model_mem[e_wa[0]] = e_wd[0];
        if (!e_busy[0]) begin
            gw = w_req && (!r_req || !last_w);
            gr = r_req && !gw;
            if (gw) begin
                e_busy[1] = 1; e_w[1] = 1; e_wa[1] = w_addr; e_wd[1] = w_data;
                m_addr = w_addr; m_wdata = w_data; last_w = 1;
            end
            if (gr) begin
                e_busy[1] = 1; e_busy[2] = 1; e_busy[3] = 1;
                e_rg[1] = 1; e_rv[3] = 1; e_ru[3] = 1; e_rd[3] = model_mem[r_addr];
                m_addr = r_addr; last_w = 0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            e_w[i] = e_w[i+1]; e_rg[i] = e_rg[i+1]; e_rv[i] = e_rv[i+1];
            e_busy[i] = e_busy[i+1]; e_ru[i] = e_ru[i+1]; e_rd[i] = e_rd[i+1];
            e_wa[i] = e_wa[i+1]; e_wd[i] = e_wd[i+1];
        end
        e_w[3] = 0; e_rg[3] = 0; e_rv[3] = 0; e_busy[3] = 0; e_ru[3] = 0;
        if (e_ru[0]) m_rdata = e_rd[0];
    endtask

    task automatic check();
        chk("w_gnt", 32'(w_gnt), 32'(e_w[0]));
        chk("mem_wen", 32'(mem_wen), 32'(e_w[0]));
        chk("r_gnt", 32'(r_gnt), 32'(e_rg[0]));
        chk("r_valid", 32'(r_valid), 32'(e_rv[0]));
        chk("busy", 32'(busy), 32'(e_busy[0]));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("r_data", 32'(r_data), 32'(m_rdata));
        if (w_gnt === 1'b1) begin gq.push_back(8'h57); wg_cyc = cyc_n; end
        if (r_gnt === 1'b1) begin gq.push_back(8'h52); rg_cyc = cyc_n; end
        if (mem_wen === 1'b1) n_wen++;
    endtask

    task automatic cyc();
        step_model();
        @(negedge clk);
        cyc_n++;
        check();
    endtask

    // Entered at a negedge; leaves at the negedge where reset is released.
    task automatic do_reset();
        n_rst = 1'b0;
        w_req = 1'b0;
        r_req = 1'b0;
        #1;
        chk("rst_w_gnt", 32'(w_gnt), 0);
        chk("rst_r_gnt", 32'(r_gnt), 0);
        chk("rst_r_valid", 32'(r_valid), 0);
        chk("rst_mem_wen", 32'(mem_wen), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_r_data", 32'(r_data), 0);
        model_reset();
        @(negedge clk);
        cyc_n++;
        n_rst = 1'b1;
        check();
    endtask

    task automatic drive_random();
        if (w_req) begin
            if (w_gnt) begin
                if ($urandom_range(0, 1) == 0) w_req = 1'b0;
                else begin w_addr = 3'($urandom_range(0, 7)); w_data = 8'($urandom_range(0, 255)); end
            end
        end else if ($urandom_range(0, 3) == 0) begin
            w_req = 1'b1; w_addr = 3'($urandom_range(0, 7)); w_data = 8'($urandom_range(0, 255));
        end
        if (r_req) begin
            if (r_gnt) begin
                if ($urandom_range(0, 1) == 0) r_req = 1'b0;
                else r_addr = 3'($urandom_range(0, 7));
            end
        end else if ($urandom_range(0, 3) == 0) begin
            r_req = 1'b1; r_addr = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        byte        exp_ord [4] = '{8'h57, 8'h52, 8'h57, 8'h52};
        logic [7:0] d;
        int         k;
        int         prev;
        n_rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single write
        w_req = 1'b1; w_addr = 3'd2; w_data = 8'hA5;
        cyc();
        chk("wr_gnt", 32'(w_gnt), 1);
        chk("wr_wen", 32'(mem_wen), 1);
        chk("wr_addr", 32'(mem_addr), 2);
        chk("wr_data", 32'(mem_wdata), 32'hA5);
        w_req = 1'b0;
        cyc();
        chk("wr_idle", 32'(busy), 0);

        // Single read of address 3
        r_req = 1'b1; r_addr = 3'd3;
        cyc();
        chk("rd_gnt", 32'(r_gnt), 1);
        r_req = 1'b0;
        cyc();
        cyc();
        chk("rd_valid", 32'(r_valid), 1);
        chk("rd_data", 32'(r_data), 32'h5C);
        cyc();
        chk("rd_hold", 32'(r_data), 32'h5C);
        chk("rd_valid_off", 32'(r_valid), 0);

        // Tie after reset: W, R, W, R
        do_reset();
        gq.delete();
        w_req = 1'b1; w_addr = 3'd1; w_data = 8'h9E;
        r_req = 1'b1; r_addr = 3'd3;
        repeat (12) cyc();
        chk("tie_count", 32'(gq.size() >= 4), 1);
        for (int i = 0; i < 4; i++)
            if (i < gq.size()) chk("tie_order", 32'(gq[i]), 32'(exp_ord[i]));
        w_req = 1'b0; r_req = 1'b0;
        repeat (4) cyc();

        // Write arriving during a read waits for the next idle cycle
        r_req = 1'b1; r_addr = 3'd5;
        cyc();
        chk("rw_rgnt", 32'(r_gnt), 1);
        r_req = 1'b0;
        cyc();
        w_req = 1'b1; w_addr = 3'd6; w_data = 8'h3C;
        k = 0;
        cyc();
        while (w_gnt !== 1'b1 && k < 8) begin cyc(); k++; end
        chk("rw_wgnt", 32'(w_gnt), 1);
        chk("rw_spacing", 32'(wg_cyc - rg_cyc), 4);
        w_req = 1'b0;
        repeat (2) cyc();

        // Reset during RD_WAIT
        r_req = 1'b1; r_addr = 3'd3;
        k = 0;
        cyc();
        while (r_gnt !== 1'b1 && k < 8) begin cyc(); k++; end
        chk("rst_rd_gnt", 32'(r_gnt), 1);
        r_req = 1'b0;
        cyc();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rst_no_rvalid", 32'(r_valid), 0);
        end

        // Back-to-back writes to addresses 0..4
        n_wen = 0;
        w_req = 1'b1;
        for (int a = 0; a < 5; a++) begin
            d = 8'($urandom_range(0, 255));
            w_addr = 3'(a); w_data = d;
            k = 0;
            cyc();
            while (w_gnt !== 1'b1 && k < 6) begin cyc(); k++; end
            chk("b2b_gnt", 32'(w_gnt), 1);
            chk("b2b_addr", 32'(mem_addr), 32'(a));
            chk("b2b_data", 32'(mem_wdata), 32'(d));
            if (a > 0) chk("b2b_spacing", 32'(wg_cyc - prev), 2);
            prev = wg_cyc;
        end
        w_req = 1'b0;
        cyc();
        chk("b2b_pulses", 32'(n_wen), 5);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else begin
                drive_random();
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter D_WIDTH, default 8, data width of the shared memory port.
REQ-002 Parameter A_WIDTH, default 3, address width of the shared memory port.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 w_req  input  1  write requester: level request, held until w_gnt.
REQ-006 w_addr  input  A_WIDTH  write address, stable while w_req=1.
REQ-007 w_data  input  D_WIDTH  write data, stable while w_req=1.
REQ-008 w_gnt  output  1  one-cycle pulse, write issued to memory this cycle.
REQ-009 r_req  input  1  read requester: level request, held until r_gnt.
REQ-010 r_addr  input  A_WIDTH  read address, stable while r_req=1.
REQ-011 r_gnt  output  1  one-cycle pulse, read address issued to memory this cycle.
REQ-012 r_valid  output  1  one-cycle pulse, r_data holds the returned read word.
REQ-013 r_data  output  D_WIDTH  last read word; holds between reads.
REQ-014 mem_addr  output  A_WIDTH  shared memory address.
REQ-015 mem_wen  output  1  shared memory write enable.
REQ-016 mem_wdata  output  D_WIDTH  shared memory write data.
REQ-017 mem_rdata  input  D_WIDTH  memory read data, valid one clock after mem_addr is presented.
REQ-018 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-019 FSM states IDLE, WR, RD, RD_WAIT, RD_DONE; all outputs registered, no combinational input-to-output path.
REQ-020 IDLE: no request -> stay IDLE; only w_req -> WR; only r_req -> RD; both -> round-robin pick.
REQ-021 Round-robin: on tie, grant the requester not granted last; last-winner flag updates on every grant; after reset, first tie goes to write.
REQ-022 On IDLE->WR edge: latch mem_addr=w_addr, mem_wdata=w_data; in WR: mem_wen=1, w_gnt=1 for exactly one cycle; WR -> IDLE unconditionally.
REQ-023 On IDLE->RD edge: latch mem_addr=r_addr; in RD: r_gnt=1, mem_wen=0; RD -> RD_WAIT.
REQ-024 RD_WAIT: capture mem_rdata into r_data at end of cycle; RD_WAIT -> RD_DONE.
REQ-025 RD_DONE: r_valid=1 one cycle; RD_DONE -> IDLE; read latency r_gnt cycle to r_valid cycle = 2 clocks.
REQ-026 Requests arriving outside IDLE are not sampled until next IDLE cycle; no request is dropped while its req stays high.
REQ-027 Requester holding req=1 after its gnt is a new back-to-back request; a requester that deasserts req on the edge after gnt gets exactly one access.
REQ-028 Minimum spacing: write every 2 cycles, read every 4 cycles; alternating tie traffic never starves either side.
REQ-029 mem_wen=1 only in WR; mem_addr/mem_wdata hold last latched values in all other states.
REQ-030 r_data changes only at end of RD_WAIT.

Reset
REQ-031 n_rst=0 forces state IDLE, last-winner=read, w_gnt=r_gnt=r_valid=mem_wen=busy=0, mem_addr=0, mem_wdata=0, r_data=0, immediately (asynchronous).
REQ-032 Reset mid-access (WR/RD/RD_WAIT/RD_DONE) aborts it: no gnt, r_valid or mem_wen pulse after release; first cycle after release is IDLE.

Verification
REQ-033 Single write: w_req=1, w_addr=2, w_data=8'hA5 for one IDLE cycle -> next cycle mem_wen=1, mem_addr=2, mem_wdata=A5, w_gnt=1; then IDLE.
REQ-034 Single read: memory[3]=8'h5C, r_req with r_addr=3 -> r_gnt cycle N, r_valid cycle N+2 with r_data=5C; r_data stays 5C afterward.
REQ-035 Tie after reset: w_req and r_req both held high -> grant order W, R, W, R...; every w_gnt followed by IDLE, every r_gnt followed by r_valid two cycles later.
REQ-036 Request during read: r_req granted, w_req rises in RD_WAIT -> w_gnt no earlier than the cycle after RD_DONE's following IDLE; write not lost.
REQ-037 Reset in RD_WAIT: n_rst low one cycle -> all outputs 0 immediately, no r_valid after release, r_data=0.
REQ-038 Back-to-back writes: w_req held, addresses 0..4 changed after each w_gnt -> five mem_wen pulses, two cycles apart, correct addr/data each.
